// File: rtl/uart_recv_if.sv
// Received-byte bus from the UART receiver to its consumer.
interface uart_recv_if;
  logic       din_vld;
  logic [7:0] din_data;
  logic       frame_err;

  modport master (output din_vld, din_data, frame_err);
  modport slave  (input  din_vld, din_data, frame_err);
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver: start-bit centre search, eight LSB-first data samples,
// stop-bit check, then a one-cycle valid or framing-error pulse.
module uart_recv #(
  parameter int unsigned FULL_T = 867,
  parameter int unsigned HALF_T = 433
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  uart_recv_if.master rx
);

  localparam int unsigned DIV_W  = 10;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic              sync1_q, sync2_q;
  logic              rxd_s;
  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              din_vld_q, din_vld_d;
  logic [DATA_W-1:0] din_data_q, din_data_d;
  logic              frame_err_q, frame_err_d;
  logic              half_hit, full_hit;

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s    = sync2_q;
  assign half_hit = (div_cnt_q == DIV_W'(HALF_T));
  assign full_hit = (div_cnt_q == DIV_W'(FULL_T));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      din_vld_q   <= 1'b0;
      din_data_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      din_vld_q   <= din_vld_d;
      din_data_q  <= din_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q + DIV_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    din_vld_d   = 1'b0;
    din_data_d  = din_data_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        if (half_hit) begin
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (full_hit) begin
          div_cnt_d                  = '0;
          shift_d[bit_cnt_q[2:0]]    = rxd_s;
          bit_cnt_d                  = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(7)) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (full_hit) begin
          div_cnt_d = '0;
          if (rxd_s) begin
            din_vld_d  = 1'b1;
            din_data_d = shift_q;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        div_cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: begin
        div_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    if (state_d != state_q) div_cnt_d = '0;
  end

  assign rx.din_vld   = din_vld_q;
  assign rx.din_data  = din_data_q;
  assign rx.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv using a shortened bit period.
module tb_uart_recv;

  localparam int unsigned FT     = 99;
  localparam int unsigned HT     = 49;
  localparam int          BIT    = FT + 1;
  localparam int          LAT    = 2 + 1 + (HT + 1) + 9 * BIT + 1;
  localparam int          GLITCH = HT / 2;

  typedef struct {
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b1;

  always #5 clk = ~clk;

  uart_recv_if rx_if ();

  uart_recv #(.FULL_T(FT), .HALF_T(HT)) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .rx  (rx_if)
  );

  exp_t       sb[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         ferr_seen = 0;
  int         ferr_exp  = 0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit good);
    exp_t e;
    @(negedge clk);
    din = 1'b0;
    if (good) begin
      e.data = d;
      e.t0   = cyc;
      sb.push_back(e);
    end
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    if (!stop) ferr_exp++;
  endtask

  // Output monitor: scoreboard pop, latency window, exclusivity, data hold
  always @(negedge clk) begin
    int   lat;
    exp_t e;
    if (rst) begin
      if (rx_if.din_vld || rx_if.frame_err)
        check("vld_ferr_mutex", int'(rx_if.din_vld & rx_if.frame_err), 0);
      if (rx_if.frame_err) ferr_seen++;
      if (rx_if.din_vld) begin
        check("vld_has_pending_frame", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e   = sb.pop_front();
          lat = cyc - e.t0;
          check("din_data", int'(rx_if.din_data), int'(e.data));
          check($sformatf("latency_%0d_in_%0d..%0d", lat, LAT - 1, LAT + 1),
                int'(lat >= LAT - 1 && lat <= LAT + 1), 1);
        end
      end else if (rx_if.din_data != prev_data) begin
        check("din_data_held", int'(rx_if.din_data), int'(prev_data));
      end
    end
    prev_data = rx_if.din_data;
  end

  initial begin
    logic [7:0] lb [3];
    logic [7:0] bad;
    lb[0] = 8'h00;
    lb[1] = 8'h7E;
    lb[2] = 8'hFF;
    bad   = 8'h96;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_din_vld",   int'(rx_if.din_vld),   0);
    check("rst_din_data",  int'(rx_if.din_data),  0);
    check("rst_frame_err", int'(rx_if.frame_err), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Basic byte
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (BIT) @(negedge clk);
    check("basic_drained", int'(sb.size()), 0);
    check("basic_data", int'(rx_if.din_data), 8'h55);

    // Back-to-back frames
    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, 1'b1);
    repeat (BIT) @(negedge clk);
    check("b2b_drained", int'(sb.size()), 0);
    check("b2b_data", int'(rx_if.din_data), 8'h00);

    // Short low glitch shorter than half a bit
    @(negedge clk);
    din = 1'b0;
    repeat (GLITCH) @(negedge clk);
    din = 1'b1;
    repeat (4 * BIT) @(negedge clk);
    check("glitch_no_ferr", ferr_seen, 0);
    check("glitch_data_kept", int'(rx_if.din_data), 8'h00);
    check("glitch_no_frame", int'(sb.size()), 0);

    // Framing error with a held-low line, then a good frame
    send_frame(8'hFF, 1'b0, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    din = 1'b1;
    repeat (BIT) @(negedge clk);
    check("ferr_count", ferr_seen, ferr_exp);
    check("ferr_data_kept", int'(rx_if.din_data), 8'h00);
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (BIT) @(negedge clk);
    check("after_ferr_data", int'(rx_if.din_data), 8'h3C);

    // Reset in the middle of data bit 4
    @(negedge clk);
    din = 1'b0;
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(bad[i]);
    @(negedge clk);
    din = bad[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_din_vld",  int'(rx_if.din_vld),  0);
    check("midrst_din_data", int'(rx_if.din_data), 0);
    din = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (BIT) @(negedge clk);
    check("after_rst_data", int'(rx_if.din_data), 8'h5A);

    // Transmitter-style byte stream
    foreach (lb[i]) send_frame(lb[i], 1'b1, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    check("stream_drained", int'(sb.size()), 0);
    check("stream_last_data", int'(rx_if.din_data), 8'hFF);
    check("final_ferr_count", ferr_seen, ferr_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
